// File: rtl/depth_tester.sv
// Per-fragment depth test: reads the stored z value, and when the new fragment is
// closer writes its colour and then its depth; otherwise the fragment is discarded.
module depth_tester #(
  parameter logic [25:0] ZB_OFFSET = 26'h0100000,
  parameter bit          CMP_LE    = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [25:0] in_addr,
  input  logic [23:0] in_color,
  input  logic [31:0] in_depth,
  input  logic        in_valid,
  input  logic        done_in,
  output logic        stall_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [25:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        done_out,
  output logic [31:0] pass_cnt,
  output logic [31:0] fail_cnt
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_COLOR, WR_DEPTH} state_t;

  state_t             state;
  logic [25:0]        frag_addr;
  logic [23:0]        frag_color;
  logic signed [31:0] frag_depth;
  logic               early_valid;
  logic signed [31:0] early_data;
  logic signed [31:0] stored_depth;
  logic               depth_valid;
  logic               depth_pass;
  logic [25:0]        frag_zaddr;
  logic [25:0]        in_zaddr;

  assign stall_out  = (state != IDLE);
  assign frag_zaddr = frag_addr + ZB_OFFSET;
  assign in_zaddr   = in_addr + ZB_OFFSET;

  // A read response that lands in the same cycle the read is accepted is parked
  // here so RD_WAIT can still act on it.
  assign stored_depth = early_valid ? early_data : mem_rdata;
  assign depth_valid  = early_valid || mem_rvalid;
  assign depth_pass   = CMP_LE ? (frag_depth <= stored_depth) : (frag_depth < stored_depth);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      frag_addr   <= '0;
      frag_color  <= '0;
      frag_depth  <= '0;
      early_valid <= 1'b0;
      early_data  <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      done_out    <= 1'b0;
      pass_cnt    <= '0;
      fail_cnt    <= '0;
    end else begin
      if (!done_in) begin
        done_out <= 1'b0;
      end else if (state == IDLE && !in_valid) begin
        done_out <= 1'b1;
      end

      case (state)
        IDLE: begin
          early_valid <= 1'b0;
          if (in_valid) begin
            frag_addr  <= in_addr;
            frag_color <= in_color;
            frag_depth <= in_depth;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= in_zaddr;
            state      <= RD_REQ;
          end
        end
        RD_REQ: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            state   <= RD_WAIT;
            if (mem_rvalid) begin
              early_valid <= 1'b1;
              early_data  <= mem_rdata;
            end
          end
        end
        RD_WAIT: begin
          if (depth_valid) begin
            early_valid <= 1'b0;
            if (depth_pass) begin
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= frag_addr;
              mem_wdata <= {8'h00, frag_color};
              state     <= WR_COLOR;
            end else begin
              fail_cnt <= fail_cnt + 32'd1;
              state    <= IDLE;
            end
          end
        end
        WR_COLOR: begin
          if (mem_ready) begin
            mem_addr  <= frag_zaddr;
            mem_wdata <= frag_depth;
            state     <= WR_DEPTH;
          end
        end
        WR_DEPTH: begin
          if (mem_ready) begin
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            pass_cnt <= pass_cnt + 32'd1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_depth_tester.sv
// Randomized scoreboard bench for depth_tester: expected memory transactions are
// queued at issue time and popped by a monitor at every accepted memory request.
module tb_depth_tester;

  localparam logic [25:0] ZB     = 26'h0100000;
  localparam bit          CMP_LE = 1'b0;
  localparam logic [31:0] FAR    = 32'h7FFF_FFFF;

  logic        clock, reset;
  logic [25:0] in_addr;
  logic [23:0] in_color;
  logic [31:0] in_depth;
  logic        in_valid, done_in, stall_out;
  logic        mem_req, mem_we, mem_ready, mem_rvalid, done_out;
  logic [25:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata, pass_cnt, fail_cnt;

  depth_tester #(.ZB_OFFSET(ZB), .CMP_LE(CMP_LE)) dut (
    .clock(clock), .reset(reset), .in_addr(in_addr), .in_color(in_color),
    .in_depth(in_depth), .in_valid(in_valid), .done_in(done_in), .stall_out(stall_out),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .done_out(done_out), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        we;
    logic [25:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] store [logic [25:0]];
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] exp_pass = 0;
  logic [31:0] exp_fail = 0;

  // Memory responder controls
  int          rd_wait = 0;
  int          rd_max = 1;
  int          rd_fixed = 0;
  logic [25:0] rd_addr = '0;
  bit          hs_flag = 0;
  bit          hold_en = 0;
  bit          rand_ready = 0;
  int          age = 0;

  logic        prev_req = 0, prev_ready = 0, prev_we = 0;
  logic [25:0] prev_addr = '0;
  logic [31:0] prev_wdata = '0;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    $display("[TB] FAIL %s: timed out", name);
  endtask

  function automatic logic [31:0] rd_resp(input logic [25:0] a);
    return store.exists(a) ? store[a] : FAR;
  endfunction

  // Monitor: compares each accepted request against the scoreboard head and
  // checks that a request held off by mem_ready does not move.
  always @(negedge clock) begin
    txn_t t;
    if (reset) begin
      if (prev_req && !prev_ready)
        check_output("req_stable", {mem_req, mem_we, mem_addr, mem_wdata},
                     {1'b1, prev_we, prev_addr, prev_wdata});
      if (mem_req && mem_ready) begin
        hs_flag = 1;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("[TB] FAIL unexpected_req: got we=%0b addr=0x%0h, expected no request", mem_we, mem_addr);
        end else begin
          t = exp_q.pop_front();
          check_output("txn_we", mem_we, t.we);
          check_output("txn_addr", mem_addr, t.addr);
          if (t.we) check_output("txn_wdata", mem_wdata, t.data);
        end
        if (!mem_we) begin
          rd_wait = (rd_fixed > 0) ? rd_fixed : $urandom_range(1, rd_max);
          rd_addr = mem_addr;
        end
      end
      prev_req = mem_req; prev_ready = mem_ready; prev_we = mem_we;
      prev_addr = mem_addr; prev_wdata = mem_wdata;
    end else begin
      prev_req = 0;
    end
  end

  // Responder: drives mem_ready and returns read data a few cycles after acceptance.
  always @(posedge clock) begin
    #1;
    if (hs_flag) begin age = 0; hs_flag = 0; end
    mem_ready = hold_en ? (age >= 5) : (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
    if (mem_req) age++;
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
    if (rd_wait > 0) begin
      rd_wait--;
      if (rd_wait == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rd_resp(rd_addr);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clock);
    while (stall_out && n < 400) begin @(negedge clock); n++; end
    if (stall_out) timeout_fail("wait_idle");
  endtask

  task automatic apply_stimulus(input logic [25:0] a, input logic [23:0] c,
                                input logic [31:0] d, output int stall_cycles);
    logic [25:0] za;
    logic [31:0] s;
    bit          pass;
    bit          fin = 0;
    wait_idle();
    za = a + ZB;
    s = rd_resp(za);
    pass = CMP_LE ? ($signed(d) <= $signed(s)) : ($signed(d) < $signed(s));
    exp_q.push_back('{1'b0, za, 32'h0});
    if (pass) begin
      exp_q.push_back('{1'b1, a, {8'h00, c}});
      exp_q.push_back('{1'b1, za, d});
    end
    in_addr = a; in_color = c; in_depth = d; in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0; in_addr = $urandom; in_color = $urandom; in_depth = $urandom;
    stall_cycles = 0;
    while (!fin) begin
      @(negedge clock);
      if (!stall_out) fin = 1;
      else begin
        stall_cycles++;
        if (stall_cycles > 400) begin timeout_fail("fragment_done"); fin = 1; end
      end
    end
    if (pass) begin store[za] = d; exp_pass++; end
    else exp_fail++;
    check_output("pass_cnt", pass_cnt, exp_pass);
    check_output("fail_cnt", fail_cnt, exp_fail);
    check_output("txn_drained", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sc;
    int n;
    logic [25:0] za;
    reset = 1'b0; in_valid = 1'b0; done_in = 1'b0;
    in_addr = '0; in_color = '0; in_depth = '0;
    mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clock);
    check_output("reset_stall", stall_out, 0);
    check_output("reset_mem", {mem_req, mem_we, mem_addr, mem_wdata}, 0);
    check_output("reset_cnt", {pass_cnt, fail_cnt}, 0);
    check_output("reset_done", done_out, 0);
    reset = 1'b1;

    // Basic pass / fail / equal with zero-wait memory
    store[26'h0100010] = 32'h0005_0000;
    apply_stimulus(26'h10, 24'hFF8040, 32'h0002_0000, sc);
    check_output("pass_stall_cycles", sc, 4);
    store[26'h0100010] = 32'h0001_0000;
    apply_stimulus(26'h10, 24'hFF8040, 32'h0002_0000, sc);
    store[26'h0100010] = 32'h0003_0000;
    apply_stimulus(26'h10, 24'h123456, 32'h0003_0000, sc);

    // Memory holds off every request for five cycles
    hold_en = 1;
    store[26'h0100040] = 32'h0100_0000;
    apply_stimulus(26'h40, 24'hABCDEF, 32'h0000_8000, sc);
    hold_en = 0;

    // Negative depth and z-address wrap
    store[26'h0100010] = 32'h0001_0000;
    apply_stimulus(26'h10, 24'h00FF00, 32'hFFFF_0000, sc);
    store[26'h00FFFF0] = 32'h0001_0000;
    apply_stimulus(26'h3FFFFF0, 24'h0000FF, 32'hFFFF_0000, sc);

    // Randomized traffic over a small address pool
    rand_ready = 1; rd_max = 3;
    for (int i = 0; i < 40; i++)
      apply_stimulus(26'($urandom_range(0, 15)) + (($urandom_range(0, 3) == 0) ? 26'h3FFFFF8 : 26'h0),
                     24'($urandom), $urandom, sc);
    rand_ready = 0; rd_max = 1;

    // done_in rises during WR_DEPTH; done_out must wait for IDLE
    hold_en = 1;
    za = 26'h20 + ZB;
    store[za] = FAR;
    fork
      apply_stimulus(26'h20, 24'h111111, 32'h0000_0100, sc);
      begin
        for (int i = 0; i < 400; i++) begin
          @(negedge clock);
          if (done_in && !stall_out) break;
          if (!done_in && mem_req && mem_we && mem_addr == za) done_in = 1'b1;
          if (done_in && stall_out) check_output("done_held_busy", done_out, 0);
        end
      end
    join
    hold_en = 0;
    check_output("done_in_raised", done_in, 1);
    check_output("done_not_yet", done_out, 0);
    @(negedge clock);
    check_output("done_set", done_out, 1);
    done_in = 1'b0;
    @(negedge clock);
    check_output("done_clear", done_out, 0);

    // Reset during RD_WAIT with a late read response
    rd_fixed = 6;
    store[26'h0100030] = 32'h0001_0000;
    wait_idle();
    exp_q.push_back('{1'b0, 26'h0100030, 32'h0});
    in_addr = 26'h30; in_color = 24'h777777; in_depth = 32'h0002_0000; in_valid = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
    n = 0;
    @(negedge clock);
    while (!(stall_out && !mem_req) && n < 50) begin @(negedge clock); n++; end
    if (!(stall_out && !mem_req)) timeout_fail("reach_rd_wait");
    #2 reset = 1'b0;
    #1;
    check_output("rst_async_stall", stall_out, 0);
    check_output("rst_async_mem", {mem_req, mem_we, mem_addr, mem_wdata}, 0);
    check_output("rst_async_cnt", {pass_cnt, fail_cnt}, 0);
    exp_q.delete();
    exp_pass = 0; exp_fail = 0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check_output("late_rvalid_idle", {stall_out, mem_req, pass_cnt, fail_cnt}, 0);
    end
    rd_fixed = 0;
    apply_stimulus(26'h30, 24'h777777, 32'h0000_0001, sc);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
